// File: rtl/operand_tf_seq.sv
// -----------------------------------------------------------------------------
// operand_tf_pkg / operand_tf_seq
//
// Control sequencer for one operand transformer lane. It accepts one even/odd
// element pair plus a shared micro scale per valid/ready transfer. It then
// drives the lane through NUM_PASSES multiply passes. Each pass is an even
// cycle followed by an odd cycle. Pass 0 reads the lane input buffer, and
// later passes read the lane feedback path. The lane's result registers are
// presented downstream on a valid/ready port.
//
// Optional feature macro: OPERAND_TF_SEQ_PERF_CNT_EN
//   defined   -> perf_blocks / perf_stalls are saturating 32-bit counters
//   undefined -> both ports are tied to 0 and no counter flops exist
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               synchronous abort of the block in flight
//   in_valid/in_ready   upstream pair handshake
//   in_elem_0/1         even/odd element          (ELEM_WIDTH_IN)
//   in_scale            shared micro scale        (SCALE_WIDTH)
//   lane_load_input     lane latches the pair on this edge
//   lane_iter_sel       0 = even element, 1 = odd element
//   lane_feedback_sel   0 = input buffer, 1 = previous result
//   lane_we_result      lane result register write enable
//   lane_elem_0/1,
//   lane_scale          combinational copies of in_*
//   lane_res_0/1        lane result registers     (ELEM_WIDTH_OUT)
//   out_valid/out_ready downstream result handshake
//   out_res_0/1         combinational copies of lane_res_*
//   perf_blocks         completed handovers
//   perf_stalls         OUT cycles blocked by out_ready
// -----------------------------------------------------------------------------
package operand_tf_pkg;
  parameter int ELEM_WIDTH_IN  = 8;
  parameter int ELEM_WIDTH_OUT = 16;
  parameter int SCALE_WIDTH    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } seq_state_e;
endpackage

module operand_tf_seq
  import operand_tf_pkg::*;
#(
  parameter int NUM_PASSES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ELEM_WIDTH_IN-1:0]  in_elem_0,
  input  logic [ELEM_WIDTH_IN-1:0]  in_elem_1,
  input  logic [SCALE_WIDTH-1:0]    in_scale,
  output logic                      lane_load_input,
  output logic                      lane_iter_sel,
  output logic                      lane_feedback_sel,
  output logic                      lane_we_result,
  output logic [ELEM_WIDTH_IN-1:0]  lane_elem_0,
  output logic [ELEM_WIDTH_IN-1:0]  lane_elem_1,
  output logic [SCALE_WIDTH-1:0]    lane_scale,
  input  logic [ELEM_WIDTH_OUT-1:0] lane_res_0,
  input  logic [ELEM_WIDTH_OUT-1:0] lane_res_1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ELEM_WIDTH_OUT-1:0] out_res_0,
  output logic [ELEM_WIDTH_OUT-1:0] out_res_1,
  output logic [31:0]               perf_blocks,
  output logic [31:0]               perf_stalls
);

  localparam int PASS_W = $clog2(NUM_PASSES) + 1;
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

  seq_state_e        r_state, w_next_state;
  logic [PASS_W-1:0] r_pass,  w_next_pass;
  logic              r_phase, w_next_phase;

  logic w_in_ready;
  logic w_out_valid;
  logic w_iter_sel;
  logic w_feedback_sel;
  logic w_we_result;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pass  <= '0;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pass  <= w_next_pass;
      r_phase <= w_next_phase;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    w_next_state   = r_state;
    w_next_pass    = r_pass;
    w_next_phase   = r_phase;
    w_in_ready     = 1'b0;
    w_out_valid    = 1'b0;
    w_iter_sel     = 1'b0;
    w_feedback_sel = 1'b0;
    w_we_result    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = ST_RUN;
          w_next_pass  = '0;
          w_next_phase = 1'b0;
        end
      end

      ST_RUN: begin
        w_we_result    = 1'b1;
        w_iter_sel     = r_phase;
        w_feedback_sel = (r_pass != '0);
        w_next_phase   = ~r_phase;
        // A pass ends on its odd cycle; the pass counter never needs to go
        // past LAST_PASS because the FSM leaves RUN at that point.
        if (r_phase) begin
          if (r_pass == LAST_PASS) begin
            w_next_state = ST_OUT;
          end else begin
            w_next_pass = r_pass + PASS_W'(1);
          end
        end
      end

      ST_OUT: begin
        w_out_valid = 1'b1;
        // The lane input buffer is independent of its result registers, so a
        // new pair may be loaded on the same edge the results are consumed.
        w_in_ready  = out_ready;
        if (out_ready) begin
          w_next_state = in_valid ? ST_RUN : ST_IDLE;
          w_next_pass  = '0;
          w_next_phase = 1'b0;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    // Flush wins over every handshake in its own cycle: nothing is accepted
    // and no result is handed over.
    if (flush) begin
      w_in_ready   = 1'b0;
      w_out_valid  = 1'b0;
      w_next_state = ST_IDLE;
      w_next_pass  = '0;
      w_next_phase = 1'b0;
    end
  end

  assign in_ready          = w_in_ready;
  assign out_valid         = w_out_valid;
  assign lane_load_input   = in_valid & w_in_ready;
  assign lane_iter_sel     = w_iter_sel;
  assign lane_feedback_sel = w_feedback_sel;
  assign lane_we_result    = w_we_result;
  assign lane_elem_0       = in_elem_0;
  assign lane_elem_1       = in_elem_1;
  assign lane_scale        = in_scale;
  assign out_res_0         = lane_res_0;
  assign out_res_1         = lane_res_1;

`ifdef OPERAND_TF_SEQ_PERF_CNT_EN
  logic [31:0] r_perf_blocks;
  logic [31:0] r_perf_stalls;

  // Counters survive flush; only rst clears them. Both saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_blocks <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (w_out_valid && out_ready && (r_perf_blocks != '1)) begin
        r_perf_blocks <= r_perf_blocks + 32'd1;
      end
      if (w_out_valid && !out_ready && (r_perf_stalls != '1)) begin
        r_perf_stalls <= r_perf_stalls + 32'd1;
      end
    end
  end

  assign perf_blocks = r_perf_blocks;
  assign perf_stalls = r_perf_stalls;
`else
  assign perf_blocks = '0;
  assign perf_stalls = '0;
`endif

endmodule
